// File: rtl/tx_pkg.sv
// Shared types and helpers for the keyed TX output stage.
//   tx_state_e  : envelope controller states
//   sat_signed(): clamp a signed value to a w-bit two's complement range
package tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RAMP_UP,
      ON,
      HANG,
      RAMP_DOWN
   } tx_state_e;

   function automatic logic signed [31:0] sat_signed(
      input logic signed [31:0] x,
      input int                 w
   );
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/tx_ramp_ctrl.sv
// Envelope controller: keying FSM, ramp prescaler, hang timer and env register.
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   key          combined PTT / CW key request
//   hang_cycles  clocks to hold full envelope after release (sampled on ON->HANG)
//   state        current FSM state
//   env          envelope value, 0..2**RAMP_LOG2
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | transmitter off, env=0
// RAMP_UP   | env climbs one step per prescaler tick toward ENV_MAX
// ON        | env held at ENV_MAX while key is down
// HANG      | key released, env held at ENV_MAX until hang timer expires
// RAMP_DOWN | env falls one step per tick toward 0
module tx_ramp_ctrl
   import tx_pkg::*;
#(
   parameter int RAMP_LOG2 = 8,
   parameter int RAMP_DIV  = 47,
   parameter int HANG_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key,
   input  logic [HANG_W-1:0]  hang_cycles,
   output tx_state_e          state,
   output logic [RAMP_LOG2:0] env
);

   localparam int PRE_W = (RAMP_DIV > 0) ? $clog2(RAMP_DIV + 1) : 1;
   localparam logic [RAMP_LOG2:0] ENV_MAX  = {1'b1, {RAMP_LOG2{1'b0}}};
   localparam logic [RAMP_LOG2:0] ENV_STEP = {{RAMP_LOG2{1'b0}}, 1'b1};
   localparam logic [PRE_W-1:0]   PRE_TC   = PRE_W'(RAMP_DIV);
   localparam logic [PRE_W-1:0]   PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
   localparam logic [HANG_W-1:0]  HANG_ONE = {{(HANG_W-1){1'b0}}, 1'b1};

   tx_state_e          state_nxt;
   logic [RAMP_LOG2:0] env_nxt;
   logic [PRE_W-1:0]   presc;
   logic [PRE_W-1:0]   presc_nxt;
   logic [HANG_W-1:0]  hang_ctr;
   logic [HANG_W-1:0]  hang_nxt;
   logic               ramping;
   logic               tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         env      <= '0;
         presc    <= '0;
         hang_ctr <= '0;
      end else begin
         state    <= state_nxt;
         env      <= env_nxt;
         presc    <= presc_nxt;
         hang_ctr <= hang_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      env_nxt   = env;
      presc_nxt = '0;
      hang_nxt  = hang_ctr;
      ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);
      tick      = (presc == PRE_TC);

      if (ramping) begin
         presc_nxt = tick ? '0 : presc + PRE_ONE;
      end

      // A key change always takes priority over a pending tick, so the
      // envelope reverses from its current value without a step.
      case (state)
         IDLE: begin
            if (key) state_nxt = RAMP_UP;
         end
         RAMP_UP: begin
            if (!key) begin
               state_nxt = RAMP_DOWN;
            end else if (env == ENV_MAX) begin
               state_nxt = ON;
            end else if (tick) begin
               env_nxt = env + ENV_STEP;
               if (env_nxt == ENV_MAX) state_nxt = ON;
            end
         end
         ON: begin
            if (!key) begin
               if (hang_cycles == '0) begin
                  state_nxt = RAMP_DOWN;
               end else begin
                  state_nxt = HANG;
                  hang_nxt  = hang_cycles;
               end
            end
         end
         HANG: begin
            if (hang_ctr != '0) hang_nxt = hang_ctr - HANG_ONE;
            if (key) begin
               state_nxt = ON;
            end else if (hang_ctr <= HANG_ONE) begin
               state_nxt = RAMP_DOWN;
            end
         end
         RAMP_DOWN: begin
            if (key) begin
               state_nxt = RAMP_UP;
            end else if (env == '0) begin
               state_nxt = IDLE;
            end else if (tick) begin
               env_nxt = env - ENV_STEP;
               if (env_nxt == '0) state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            env_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/tx_keying_shaper.sv
// Keyed TX output stage between the CORDIC upconverter and the DAC.
// Shapes the RF sample with a linear keying envelope, attenuates, saturates
// to the DAC width and drives a heartbeat LED.
// Ports:
//   clk          sample clock, rising edge
//   reset        synchronous, active-high
//   ptt          host PTT request
//   cw_key       CW key (ORed with ptt)
//   hang_cycles  clocks to hold full envelope after key release
//   in_data      signed RF sample, one per clock
//   out_data     signed DAC sample, 2-clock latency from in_data
//   tx_active    high while not idle (registered)
//   env_full     high in ON/HANG; PA/TR switching allowed only when low
//   led          heartbeat: fast bit while transmitting, slow bit when idle
module tx_keying_shaper
   import tx_pkg::*;
#(
   parameter int IN_W      = 16,
   parameter int DAC_W     = 12,
   parameter int SHIFT     = 2,
   parameter int RAMP_LOG2 = 8,
   parameter int RAMP_DIV  = 47,
   parameter int HANG_W    = 16,
   parameter int LED_FAST  = 24,
   parameter int LED_SLOW  = 26
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ptt,
   input  logic                    cw_key,
   input  logic [HANG_W-1:0]       hang_cycles,
   input  logic signed [IN_W-1:0]  in_data,
   output logic signed [DAC_W-1:0] out_data,
   output logic                    tx_active,
   output logic                    env_full,
   output logic                    led
);

   localparam int PROD_W = IN_W + RAMP_LOG2 + 2;
   localparam int CTR_W  = LED_SLOW + 1;
   localparam int DROP   = RAMP_LOG2 + SHIFT;
   localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

   tx_state_e                state;
   logic [RAMP_LOG2:0]       env;
   logic                     key;
   logic signed [PROD_W-1:0] prod;
   logic [CTR_W-1:0]         led_ctr;

   assign key = ptt | cw_key;

   tx_ramp_ctrl #(
      .RAMP_LOG2 (RAMP_LOG2),
      .RAMP_DIV  (RAMP_DIV),
      .HANG_W    (HANG_W)
   ) u_ramp (
      .clk         (clk),
      .reset       (reset),
      .key         (key),
      .hang_cycles (hang_cycles),
      .state       (state),
      .env         (env)
   );

   // env is unsigned; the zero-extended copy keeps the multiply signed.
   // Dividing by 2**RAMP_LOG2 makes ENV_MAX an exact unity gain.
   always_ff @(posedge clk) begin
      if (reset) begin
         prod      <= '0;
         out_data  <= '0;
         tx_active <= 1'b0;
         env_full  <= 1'b0;
         led_ctr   <= '0;
      end else begin
         prod <= in_data * $signed({1'b0, env});
         if (state == IDLE) begin
            out_data <= '0;
         end else begin
            out_data <= DAC_W'(sat_signed(32'(prod >>> DROP), DAC_W));
         end
         tx_active <= (state != IDLE);
         env_full  <= (state == ON) || (state == HANG);
         led_ctr   <= led_ctr + CTR_ONE;
      end
   end

   assign led = tx_active ? led_ctr[LED_FAST] : led_ctr[LED_SLOW];

endmodule

// File: tb/tb_tx_keying_shaper.sv
module tb_tx_keying_shaper;

   localparam int IN_W  = 16;
   localparam int DAC_W = 12;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    ptt;
   logic                    cw_key;
   logic                    ptt2;
   logic [15:0]             hang_cycles;
   logic signed [IN_W-1:0]  in_data;
   logic signed [DAC_W-1:0] out_data;
   logic signed [DAC_W-1:0] out_data2;
   logic                    tx_active;
   logic                    env_full;
   logic                    led;
   logic                    tx_active2;
   logic                    env_full2;
   logic                    led2;

   int total = 0;
   int bad   = 0;

   int t4_in [12] = '{-32768, 32767, -1000, -3, 4, -4, 8187, 8188, 8192, -8188, -8192, -8193};
   int t4_exp[12] = '{ -2048,  2047,  -250, -1, 1, -1, 2046, 2047, 2047, -2047, -2048, -2048};

   always #5 clk = ~clk;

   tx_keying_shaper #(
      .IN_W(16), .DAC_W(12), .SHIFT(2), .RAMP_LOG2(8), .RAMP_DIV(0),
      .HANG_W(16), .LED_FAST(2), .LED_SLOW(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ptt         (ptt),
      .cw_key      (cw_key),
      .hang_cycles (hang_cycles),
      .in_data     (in_data),
      .out_data    (out_data),
      .tx_active   (tx_active),
      .env_full    (env_full),
      .led         (led)
   );

   // Second instance with a real prescaler (one env step per 4 clocks).
   tx_keying_shaper #(
      .IN_W(16), .DAC_W(12), .SHIFT(2), .RAMP_LOG2(8), .RAMP_DIV(3),
      .HANG_W(16), .LED_FAST(2), .LED_SLOW(4)
   ) dut2 (
      .clk         (clk),
      .reset       (reset),
      .ptt         (ptt2),
      .cw_key      (1'b0),
      .hang_cycles (hang_cycles),
      .in_data     (in_data),
      .out_data    (out_data2),
      .tx_active   (tx_active2),
      .env_full    (env_full2),
      .led         (led2)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b1;
      ptt         = 1'b0;
      cw_key      = 1'b0;
      ptt2        = 1'b0;
      hang_cycles = 16'd10;
      in_data     = 16'sd16000;
      step(3);
      chk("rst_out", out_data, 0);
      chk("rst_txa", tx_active, 0);
      chk("rst_envf", env_full, 0);
      chk("rst_led", led, 0);

      // full ramp up, RAMP_DIV=0
      reset = 1'b0;
      ptt   = 1'b1;
      ptt2  = 1'b1;
      step(1);   chk("t1_txa_e1", tx_active, 0);
      step(1);   chk("t1_txa_e2", tx_active, 1);
                 chk("t1_envf_e2", env_full, 0);
                 chk("t1_txa2_e2", tx_active2, 1);
      step(1);   chk("t1_out_e3", out_data, 0);
      step(1);   chk("t1_out_e4", out_data, 15);
                 chk("t1_led_e4", led, 1);
                 chk("t1_led2_e4", led2, 1);
      step(2);   chk("t1_out2_e6", out_data2, 0);
      step(1);   chk("t1_out2_e7", out_data2, 15);
      step(3);   chk("t1_out2_e10", out_data2, 15);
      step(1);   chk("t1_out2_e11", out_data2, 31);
      step(2);   chk("t1_out_e13", out_data, 156);
                 chk("t1_led_e13", led, 1);
                 chk("t1_envf2_e13", env_full2, 0);
      step(54);  chk("t1_out_e67", out_data, 1000);
                 chk("t1_led_e67", led, 0);
      step(64);  chk("t1_out_e131", out_data, 2000);
      step(3);   chk("t1_out_e134", out_data, 2046);
      step(1);   chk("t1_out_e135", out_data, 2047);
      step(122); chk("t1_envf_e257", env_full, 0);
      step(1);   chk("t1_envf_e258", env_full, 1);
                 chk("t1_out_e258", out_data, 2047);

      // release with hang of 10, ramp down to idle
      ptt = 1'b0;
      step(11);  chk("t2_envf_hang_end", env_full, 1);
                 chk("t2_txa_hang", tx_active, 1);
      step(1);   chk("t2_envf_drop", env_full, 0);
                 chk("t2_out_full", out_data, 2047);
      step(130); chk("t2_out_mid", out_data, 1984);
      step(125); chk("t2_out_last", out_data, 31);
                 chk("t2_txa_last", tx_active, 1);
      step(1);   chk("t2_out_idle", out_data, 0);
                 chk("t2_txa_idle", tx_active, 0);

      // zero hang goes straight to ramp down; re-key at env=100
      hang_cycles = 16'd0;
      ptt         = 1'b1;
      step(257);
      ptt = 1'b0;
      step(1);   chk("t3_envf_on", env_full, 1);
      step(1);   chk("t3_envf_nohang", env_full, 0);
      step(155);
      ptt = 1'b1;
      step(1);   chk("t3_out_101a", out_data, 1578);
      step(1);   chk("t3_out_100a", out_data, 1562);
      step(1);   chk("t3_out_100b", out_data, 1562);
      step(1);   chk("t3_out_101b", out_data, 1578);

      // CW key pulses shorter than hang keep full envelope
      step(154);
      hang_cycles = 16'd10;
      cw_key      = 1'b1;
      ptt         = 1'b0;
      step(2);   chk("t5_envf_on", env_full, 1);
                 chk("t5_out_on", out_data, 2047);
      for (int p = 0; p < 2; p++) begin
         cw_key = 1'b0;
         step(3);  chk("t5_envf_gap", env_full, 1);
                   chk("t5_txa_gap", tx_active, 1);
         cw_key = 1'b1;
         step(2);  chk("t5_envf_rekey", env_full, 1);
                   chk("t5_out_rekey", out_data, 2047);
      end
      cw_key = 1'b0;
      step(9);
      cw_key = 1'b1;
      step(1);   chk("t5_envf_long_a", env_full, 1);
      step(1);   chk("t5_envf_long_b", env_full, 1);
      step(2);   chk("t5_out_long", out_data, 2047);

      // hang_cycles change mid-HANG must not affect the running hang
      cw_key = 1'b0;
      step(1);
      hang_cycles = 16'd200;
      step(10);  chk("t5_envf_hang10", env_full, 1);
      step(1);   chk("t5_envf_hang_exp", env_full, 0);
      step(255); chk("t5_txa_down", tx_active, 1);
      step(1);   chk("t5_txa_idle", tx_active, 0);
                 chk("t5_out_idle", out_data, 0);

      // saturation and rounding at full envelope
      hang_cycles = 16'd10;
      ptt         = 1'b1;
      step(258); chk("t4_envf", env_full, 1);
      for (int i = 0; i < 12; i++) begin
         in_data = IN_W'(t4_in[i]);
         step(2);
         chk($sformatf("t4_sat_%0d", t4_in[i]), out_data, t4_exp[i]);
      end

      // reset while ON, then reset mid RAMP_UP
      reset = 1'b1;
      step(1);   chk("t6_out_rst_on", out_data, 0);
                 chk("t6_txa_rst_on", tx_active, 0);
                 chk("t6_envf_rst_on", env_full, 0);
      reset   = 1'b0;
      in_data = 16'sd16000;
      step(50);  chk("t6_out_ramp", out_data, 734);
      reset = 1'b1;
      step(1);   chk("t6_out_rst", out_data, 0);
                 chk("t6_txa_rst", tx_active, 0);
                 chk("t6_envf_rst", env_full, 0);
                 chk("t6_led_rst", led, 0);
      reset = 1'b0;
      ptt   = 1'b0;
      step(15);  chk("t6_led_15", led, 0);
                 chk("t6_out_idle15", out_data, 0);
      step(1);   chk("t6_led_16", led, 1);
                 chk("t6_out_idle16", out_data, 0);
                 chk("t6_txa_idle16", tx_active, 0);
      ptt = 1'b1;
      step(3);   chk("t6_out_e3", out_data, 0);
      step(1);   chk("t6_out_e4", out_data, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
